// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared types and constants for the data-memory responder.
//   state_t             : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W, BYTE_OFF_W  : word width and byte-offset width of the address
//   DEFAULT_DEPTH_WORDS : default array depth in words
//   ERR_READ_DATA       : value returned on mem_output for a rejected access
//   word_idx_w()        : word-index width for a given depth ($clog2)
// -----------------------------------------------------------------------------
package data_mem_pkg;

    localparam int DATA_W              = 32;
    localparam int BYTE_OFF_W          = 2;
    localparam int DEFAULT_DEPTH_WORDS = 1024;

    localparam logic [DATA_W-1:0] ERR_READ_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int word_idx_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bundle between the pipeline memory stage and the responder.
//   mem_address [31:0] : byte address (stage -> responder)
//   mem_input   [31:0] : write data   (stage -> responder)
//   mem_enable         : access request, level-sensitive
//   mem_r_w            : 1 = write, 0 = read
//   mem_output  [31:0] : read data, valid with mem_ready (responder -> stage)
//   mem_ready          : one-cycle completion pulse
//   mem_error          : completion of a rejected access
//   mem_stall          : pipeline freeze while an access is outstanding
// master = memory stage side, slave = responder side.
// -----------------------------------------------------------------------------
interface data_mem_responder_if;

    logic [31:0] mem_address;
    logic [31:0] mem_input;
    logic        mem_enable;
    logic        mem_r_w;
    logic [31:0] mem_output;
    logic        mem_ready;
    logic        mem_error;
    logic        mem_stall;

    modport master (
        output mem_address, mem_input, mem_enable, mem_r_w,
        input  mem_output, mem_ready, mem_error, mem_stall
    );

    modport slave (
        input  mem_address, mem_input, mem_enable, mem_r_w,
        output mem_output, mem_ready, mem_error, mem_stall
    );

endinterface

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Single-port DEPTH_WORDS x DATA_W word array, synchronous write and
// synchronous (registered) read. Contents are never reset.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata to addr, 0 = register mem[addr] into rdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, changes only on an enabled read
// -----------------------------------------------------------------------------
module data_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Services one word access from the memory stage at a time: accepts the
// request in IDLE, waits LATENCY cycles, then completes with a one-cycle
// mem_ready pulse (plus mem_error if the address was misaligned or beyond
// the array). mem_stall freezes the pipeline while an access is pending.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : data_mem_responder_if.slave (request in, response/stall out)
// Parameters: DEPTH_WORDS (power of two, >= 4), LATENCY (0..15).
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int         IDX_W = word_idx_w(DEPTH_WORDS);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   out_q, out_d;

    logic                acc_err;
    logic                issue_now;
    logic                issue_wait;
    logic                resp_w;
    logic                ram_en;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // Rejection decided from the live address at the moment of acceptance.
    assign acc_err = (bus.mem_address[BYTE_OFF_W-1:0] != '0) ||
                     (bus.mem_address[31:BYTE_OFF_W] >= 30'(DEPTH_WORDS));

    // State and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    // Next state, counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_enable) begin
                    addr_d  = bus.mem_address[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
                    wdata_d = bus.mem_input;
                    rw_d    = bus.mem_r_w;
                    err_d   = acc_err;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs and array control.
    always_comb begin
        // With zero latency the array is driven straight from the bus in the
        // accept cycle, since the request registers are not loaded yet.
        issue_now  = (state_q == IDLE) && bus.mem_enable && (LAT == 4'd0);
        issue_wait = (state_q == WAIT) && (cnt_q == 4'd1);
        resp_w     = (state_q == RESP);

        // Gating with reset keeps a reset coinciding with the RESP-entry
        // edge from committing the write.
        ram_en    = !reset && ((issue_now && !acc_err) || (issue_wait && !err_q));
        ram_we    = issue_now ? bus.mem_r_w : rw_q;
        ram_addr  = issue_now ? bus.mem_address[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W] : addr_q;
        ram_wdata = issue_now ? bus.mem_input : wdata_q;

        // out_q holds the last completed read; a RESP cycle can override it.
        out_d = out_q;
        if (resp_w) begin
            if (err_q) begin
                out_d = ERR_READ_DATA;
            end else if (!rw_q) begin
                out_d = ram_rdata;
            end
        end

        bus.mem_ready  = resp_w;
        bus.mem_error  = resp_w && err_q;
        bus.mem_output = resp_w ? out_d : out_q;
        bus.mem_stall  = bus.mem_enable && !resp_w;
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W),
        .DATA_W      (DATA_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders side by side: index 0 with LATENCY=2/DEPTH=1024, index 1
// with LATENCY=0/DEPTH=16. The driver pushes one expectation per accepted
// request; the negedge monitor pops when a response is due and compares.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          err;
        int          resp_cyc;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] drv_addr [2];
    logic [31:0] drv_data [2];
    logic        drv_en   [2];
    logic        drv_rw   [2];
    logic [31:0] mon_out  [2];
    logic        mon_rdy  [2];
    logic        mon_err  [2];
    logic        mon_stall[2];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    req_t        exp_q [2][$];
    logic [31:0] ref_mem [2][1024];
    logic [31:0] out_model [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        data_mem_responder_if bus_if();
        assign bus_if.mem_address = drv_addr[gi];
        assign bus_if.mem_input   = drv_data[gi];
        assign bus_if.mem_enable  = drv_en[gi];
        assign bus_if.mem_r_w     = drv_rw[gi];
        assign mon_out[gi]        = bus_if.mem_output;
        assign mon_rdy[gi]        = bus_if.mem_ready;
        assign mon_err[gi]        = bus_if.mem_error;
        assign mon_stall[gi]      = bus_if.mem_stall;

        data_mem_responder #(
            .DEPTH_WORDS ((gi == 0) ? 1024 : 16),
            .LATENCY     ((gi == 0) ? 2 : 0)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_if)
        );
    end

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one access to responder d, which must be idle. Returns in the
    // cycle after the responder is back in IDLE. hold keeps mem_enable high
    // for a back-to-back follow-up; toggle scrambles address/data while busy.
    task automatic access(input int d, input bit rw, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold, input bit toggle);
        req_t r;
        drv_rw[d]   = rw;
        drv_addr[d] = addr;
        drv_data[d] = data;
        drv_en[d]   = 1'b1;
        @(posedge clk); #1;
        r.rw        = rw;
        r.addr      = addr;
        r.wdata     = data;
        r.err       = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth(d)));
        r.exp_rdata = (r.err || rw) ? 32'h0 : ref_mem[d][int'(addr[31:2])];
        // Ready is due LATENCY cycles after the first cycle following the accept edge.
        r.resp_cyc  = cyc + lat(d);
        exp_q[d].push_back(r);
        for (int i = 0; i <= lat(d); i++) begin
            if (toggle) begin
                drv_addr[d] = $urandom;
                drv_data[d] = $urandom;
            end
            @(posedge clk); #1;
        end
        if (!hold) drv_en[d] = 1'b0;
    endtask

    task automatic flush_model();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            out_model[d] = 32'h0;
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        req_t        r;
        bit          exp_rdy;
        logic [31:0] exp_out;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = (exp_q[d].size() > 0) && (exp_q[d][0].resp_cyc == cyc);
            check($sformatf("ready_d%0d", d), {31'b0, mon_rdy[d]}, {31'b0, exp_rdy});
            check($sformatf("stall_d%0d", d), {31'b0, mon_stall[d]},
                  {31'b0, drv_en[d] & ~exp_rdy});
            if (exp_rdy || mon_rdy[d]) begin
                if (exp_rdy) begin
                    r = exp_q[d].pop_front();
                    exp_out = r.err ? 32'h0 : (r.rw ? out_model[d] : r.exp_rdata);
                    check($sformatf("error_d%0d", d), {31'b0, mon_err[d]}, {31'b0, r.err});
                    check($sformatf("output_d%0d", d), mon_out[d], exp_out);
                    if (!r.err && r.rw) ref_mem[d][int'(r.addr[31:2])] = r.wdata;
                    out_model[d] = exp_out;
                    $display("resp d%0d cyc=%0d %s addr=%h wdata=%h out=%h err=%0b",
                             d, cyc, r.rw ? "WR" : "RD", r.addr, r.wdata, mon_out[d], mon_err[d]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        for (int d = 0; d < 2; d++) begin
            drv_en[d] = 1'b0; drv_rw[d] = 1'b0; drv_addr[d] = 32'h0; drv_data[d] = 32'h0;
            out_model[d] = 32'h0;
        end

        // Reset values; stall follows enable while in reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_out",   mon_out[d], 32'h0);
            check("rst_ready", {31'b0, mon_rdy[d]}, 32'h0);
            check("rst_error", {31'b0, mon_err[d]}, 32'h0);
        end
        drv_en[0] = 1'b1;
        #1 check("rst_stall_follows_en", {31'b0, mon_stall[0]}, 32'h1);
        drv_en[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // LATENCY=0: held back-to-back writes then reads.
        access(1, 1'b1, 32'h0, 32'hA, 1'b1, 1'b0);
        access(1, 1'b1, 32'h4, 32'hB, 1'b1, 1'b0);
        access(1, 1'b1, 32'h8, 32'hC, 1'b1, 1'b0);
        access(1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
        access(1, 1'b0, 32'd64, 32'h0, 1'b0, 1'b0);   // one past a 16-word array

        // LATENCY=2: write then read-after-write.
        access(0, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b0);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

        // Misaligned write is rejected and leaves the word intact.
        access(0, 1'b1, 32'h40, 32'h1111_1111, 1'b0, 1'b0);
        access(0, 1'b1, 32'h42, 32'hFFFF_FFFF, 1'b0, 1'b0);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

        // Out-of-range read.
        access(0, 1'b0, 32'd4096, 32'h0, 1'b0, 1'b0);

        // Reset during WAIT discards the write.
        access(0, 1'b1, 32'h10, 32'h5, 1'b0, 1'b0);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        drv_rw[0] = 1'b1; drv_addr[0] = 32'h10; drv_data[0] = 32'hDEAD_0001; drv_en[0] = 1'b1;
        @(posedge clk); #1;
        drv_en[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        flush_model();
        @(negedge clk);
        check("midwait_rst_out",   mon_out[0], 32'h0);
        check("midwait_rst_ready", {31'b0, mon_rdy[0]}, 32'h0);
        check("midwait_rst_error", {31'b0, mon_err[0]}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

        // Bus scrambled while busy: captured values must be used.
        access(0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b1);
        access(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);

        // Randomised traffic over a small pool of words.
        for (int i = 0; i < 8; i++) access(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            if (sel == 1) a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
            access(0, 1'($urandom_range(0, 1)), a, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drv_en[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            check("queue_drained", 32'(exp_q[d].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
